// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared encodings for the M stage.
//   ResultSrc selects, funct3 load/store codes, access-size codes,
//   FSM state enum and the MEM/WB register layout.
package memory_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] gives the access size for both loads and stores
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_out;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] inc_pc;
  } mw_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the data memory port.
//   funct3, addr_lo  : access size/sign and low address bits
//   is_store         : select store byte enables (loads read the full word)
//   store_data       : raw rs2 value
//   rdata            : word returned by memory
//   be, wdata        : byte enables and lane-replicated store data
//   load_data        : selected and sign/zero-extended load result
//   misaligned       : halfword on odd address or word not on a 4-byte boundary
module lsu_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // funct3[1:0]==11 decodes as a plain word load and is never flagged
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

  // Store data is replicated across every lane so the byte enables alone
  // pick the target bytes.
  always_comb begin
    be    = 4'hF;
    wdata = store_data;
    if (is_store) begin
      case (funct3[1:0])
        SZ_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SZ_H: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'hF;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = rdata;  // LW and the unused 011/11x codes
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: M stage of the RV32I pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   *M inputs           : EX/MEM register fields
//   mem_*               : data memory req/ack port (ack may land in the req cycle)
//   MemStall            : freezes IF/ID/EX and EX/MEM while an access waits
//   AlignErr / BusErr   : one-cycle pulses for a dropped misaligned access / timeout
//   *W outputs          : MEM/WB register
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // 0 = wait for ack forever
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUoutM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] Rd2M,
  input  logic [31:0] inc_PCM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        MemStall,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] inc_PCW
);

  localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state;
  logic [15:0] wait_cnt;
  mw_t         mw;

  logic        acc, misal, to_hit;
  logic        req_c, stall_c, align_c, bus_c;
  logic [31:0] load_data;

  assign acc    = MemWriteM | (ResultSrcM == RES_MEM);
  assign to_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  lsu_align u_align (
    .funct3    (funct3M),
    .addr_lo   (ALUoutM[1:0]),
    .is_store  (MemWriteM),
    .store_data(Rd2M),
    .rdata     (mem_rdata),
    .be        (mem_be),
    .wdata     (mem_wdata),
    .load_data (load_data),
    .misaligned(misal)
  );

  // Request/stall decode. In WAIT the request stays up through the timeout
  // cycle so a last-moment ack still completes the access; the drop is
  // visible the cycle after. Everything is masked during reset.
  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    align_c = 1'b0;
    bus_c   = 1'b0;
    if (!rst) begin
      if (state == S_IDLE) begin
        if (acc && misal) begin
          align_c = 1'b1;
        end else if (acc) begin
          req_c   = 1'b1;
          stall_c = !mem_ack;
        end
      end else begin
        req_c = 1'b1;
        if (!mem_ack) begin
          if (to_hit) bus_c   = 1'b1;
          else        stall_c = 1'b1;
        end
      end
    end
  end

  assign mem_req  = req_c;
  assign mem_we   = req_c & MemWriteM;
  assign mem_addr = {ALUoutM[31:2], 2'b00};
  assign MemStall = stall_c;
  assign AlignErr = align_c;
  assign BusErr   = bus_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mw       <= '0;
    end else begin
      // Stall, dropped and aborted cycles become bubbles so W commits once.
      mw.reg_write  <= RegWriteM & ~(stall_c | align_c | bus_c);
      mw.result_src <= ResultSrcM;
      mw.alu_out    <= ALUoutM;
      mw.read_data  <= load_data;
      mw.rd         <= RdM;
      mw.inc_pc     <= inc_PCM;
      case (state)
        S_IDLE: begin
          if (req_c && !mem_ack) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (mem_ack || bus_c) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign RegWriteW  = mw.reg_write;
  assign ResultSrcW = mw.result_src;
  assign ALUoutW    = mw.alu_out;
  assign ReadDataW  = mw.read_data;
  assign RdW        = mw.rd;
  assign inc_PCW    = mw.inc_pc;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: table vectors, hand-written corner sequences and random
// accesses checked against a size/offset arithmetic model of the LSU.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, mem_ack;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUoutM, Rd2M, inc_PCM, mem_rdata;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, MemStall, AlignErr, BusErr, RegWriteW;
  logic [31:0] mem_addr, mem_wdata, ALUoutW, ReadDataW, inc_PCW;
  logic [3:0]  mem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .ALUoutM(ALUoutM), .funct3M(funct3M), .RdM(RdM),
    .Rd2M(Rd2M), .inc_PCM(inc_PCM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .MemStall(MemStall),
    .AlignErr(AlignErr), .BusErr(BusErr), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUoutW(ALUoutW), .ReadDataW(ReadDataW),
    .RdW(RdW), .inc_PCW(inc_PCW)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---- reference model: access size in bytes and byte offset arithmetic ----
  function automatic int sz_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1'b0;
    return (int'(a[1:0]) % sz_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz = sz_of(f3);
    if (!st || sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = sz_of(f3);
    logic [63:0] mask, w;
    mask = (sz == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * sz)) - 1);
    w = 0;
    for (int i = 0; i < 4; i += sz) w |= ({32'b0, d} & mask) << (8 * i);
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int sz = sz_of(f3);
    logic [31:0] mask, v;
    if (sz == 4) return word;
    mask = (32'd1 << (8 * sz)) - 1;
    v = (word >> (8 * a[1:0])) & mask;
    if (!f3[2] && v[8 * sz - 1]) v |= ~mask;
    return v;
  endfunction

  task automatic drive_nop();
    RegWriteM  = 1'b0;
    ResultSrcM = RES_ALU;
    MemWriteM  = 1'b0;
    ALUoutM    = $urandom;
    funct3M    = 3'($urandom);
    RdM        = 5'($urandom);
    Rd2M       = $urandom;
    inc_PCM    = $urandom;
    mem_ack    = 1'b0;
    mem_rdata  = $urandom;
  endtask

  // Entered and left at posedge+1. Memory acks lat cycles after the request
  // cycle (lat > TO means never).
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rd2, input logic [31:0] rdata, input int lat,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rdw,
                        input logic e_mis, input logic [4:0] rd, input string tag);
    logic [31:0] pc4;
    logic ack, to;
    pc4 = $urandom;
    RegWriteM = !st; ResultSrcM = st ? RES_ALU : RES_MEM; MemWriteM = st;
    ALUoutM = addr; funct3M = f3; RdM = rd; Rd2M = rd2; inc_PCM = pc4;
    for (int c = 0; c <= int'(TO) + 1; c++) begin
      ack = !e_mis && (c == lat);
      to  = !e_mis && !ack && (c == int'(TO));
      mem_ack = ack;
      mem_rdata = ack ? rdata : $urandom;
      @(negedge clk);
      chk({tag, " AlignErr"}, AlignErr, e_mis);
      chk({tag, " mem_req"}, mem_req, !e_mis);
      chk({tag, " MemStall"}, MemStall, !(e_mis || ack || to));
      chk({tag, " BusErr"}, BusErr, to);
      if (!e_mis) begin
        chk({tag, " mem_we"}, mem_we, st);
        chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, " mem_be"}, mem_be, e_be);
        if (st) chk({tag, " mem_wdata"}, mem_wdata, e_wd);
      end
      @(posedge clk); #1;
      if (e_mis || ack || to) begin
        chk({tag, " RegWriteW"}, RegWriteW, ack && !st);
        if (ack) begin
          chk({tag, " RdW"}, RdW, rd);
          chk({tag, " ALUoutW"}, ALUoutW, addr);
          chk({tag, " inc_PCW"}, inc_PCW, pc4);
          chk({tag, " ResultSrcW"}, ResultSrcW, st ? RES_ALU : RES_MEM);
          if (!st) chk({tag, " ReadDataW"}, ReadDataW, e_rdw);
        end
        break;
      end
      chk({tag, " bubble"}, RegWriteW, 0);
    end
    drive_nop();
    @(negedge clk);
    chk({tag, " req after"}, mem_req, 0);
    chk({tag, " stall after"}, MemStall, 0);
    chk({tag, " BusErr after"}, BusErr, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, rd2, rdata;
    logic [3:0]  be;
    logic [31:0] wd, rdw;
    logic        mis;
  } vec_t;

  vec_t tv[11];
  int          kind, lat;
  logic        st;
  logic [2:0]  f3;
  logic [31:0] addr, d, w, pc;
  logic [4:0]  rd;
  logic        rw;
  logic [1:0]  rs;

  initial begin
    tv[0]  = '{1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tv[1]  = '{1'b1, F3_H,  32'h202, 32'h0000ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0,        1'b0};
    tv[2]  = '{1'b1, F3_B,  32'h101, 32'h000000A5, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h0,        1'b0};
    tv[3]  = '{1'b1, F3_H,  32'h200, 32'h12345678, 32'h0,        4'h3, 32'h56785678, 32'h0,        1'b0};
    tv[4]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'hFFFFFF80, 1'b0};
    tv[5]  = '{1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h00000080, 1'b0};
    tv[6]  = '{1'b0, F3_H,  32'h202, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'hFFFF80FF, 1'b0};
    tv[7]  = '{1'b0, F3_HU, 32'h200, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h00001234, 1'b0};
    tv[8]  = '{1'b0, F3_B,  32'h101, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h00000012, 1'b0};
    tv[9]  = '{1'b0, F3_H,  32'h201, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h0,        1'b1};
    tv[10] = '{1'b1, F3_W,  32'h102, 32'h11112222, 32'h0,        4'hF, 32'h0,        32'h0,        1'b1};

    // Reset with a load presented: request must stay masked, MW cleared.
    rst = 1'b1;
    drive_nop();
    ResultSrcM = RES_MEM; funct3M = F3_W; ALUoutM = 32'h40;
    @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst MemStall", MemStall, 0);
    chk("rst AlignErr", AlignErr, 0);
    chk("rst BusErr", BusErr, 0);
    chk("rst MW", {RegWriteW, ResultSrcW, RdW} | ALUoutW | ReadDataW | inc_PCW, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      access(tv[i].st, tv[i].f3, tv[i].addr, tv[i].rd2, tv[i].rdata, 0, tv[i].be,
             tv[i].wd, tv[i].rdw, tv[i].mis, 5'(i + 1), $sformatf("vec%0d", i));

    // Delayed acks and a timeout.
    access(1'b0, F3_B,  32'h103, 32'h0, 32'h80FF1234, 3, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0, 5'd12, "LB wait3");
    access(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, 3, 4'hF, 32'h0, 32'h00000080, 1'b0, 5'd13, "LBU wait3");
    access(1'b0, F3_W,  32'h300, 32'h0, 32'h0, 100, 4'hF, 32'h0, 32'h0, 1'b0, 5'd14, "LW timeout");
    access(1'b0, F3_W,  32'h304, 32'h0, 32'h5A5A0F0F, int'(TO), 4'hF, 32'h0, 32'h5A5A0F0F, 1'b0, 5'd15, "LW ack at timeout");

    // Reset during the second WAIT cycle aborts silently.
    RegWriteM = 1'b1; ResultSrcM = RES_MEM; MemWriteM = 1'b0; ALUoutM = 32'h400;
    funct3M = F3_W; RdM = 5'd9; inc_PCM = 32'h44; mem_ack = 1'b0;
    @(negedge clk); chk("rstW req stall", MemStall, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rstW wait1 stall", MemStall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstW mem_req", mem_req, 0);
    chk("rstW MemStall", MemStall, 0);
    chk("rstW BusErr", BusErr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    chk("rstW MW", {RegWriteW, ResultSrcW, RdW} | ALUoutW | ReadDataW | inc_PCW, 0);
    @(negedge clk);
    chk("rstW after req", mem_req, 0);
    chk("rstW after stall", MemStall, 0);
    chk("rstW after BusErr", BusErr, 0);
    @(posedge clk); #1;

    // ADD followed directly by a zero-wait LW.
    RegWriteM = 1'b1; ResultSrcM = RES_ALU; MemWriteM = 1'b0; ALUoutM = 32'd7; RdM = 5'd3;
    @(negedge clk);
    chk("add MemStall", MemStall, 0);
    chk("add mem_req", mem_req, 0);
    @(posedge clk); #1;
    chk("add ALUoutW", ALUoutW, 32'd7);
    chk("add RdW", RdW, 5'd3);
    chk("add RegWriteW", RegWriteW, 1);
    access(1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 5'd4, "b2b LW");

    // Random mix against the model.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        rw = 1'($urandom); rs = $urandom_range(0, 1) ? RES_ALU : RES_PC4;
        addr = $urandom; rd = 5'($urandom); pc = $urandom;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = 1'b0; ALUoutM = addr; RdM = rd; inc_PCM = pc;
        @(negedge clk);
        chk("rnd alu req", mem_req, 0);
        chk("rnd alu stall", MemStall, 0);
        @(posedge clk); #1;
        chk("rnd alu W", {RegWriteW, ResultSrcW, RdW}, {rw, rs, rd});
        chk("rnd alu ALUoutW", ALUoutW, addr);
        chk("rnd alu inc_PCW", inc_PCW, pc);
      end else begin
        st = (kind == 2);
        f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom);
        addr = $urandom;
        if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
        d = $urandom; w = $urandom; rd = 5'($urandom);
        lat = $urandom_range(0, int'(TO) + 1);
        access(st, f3, addr, d, w, lat, m_be(st, f3, addr), m_wdata(f3, d),
               m_load(f3, addr, w), m_mis(f3, addr), rd, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
